// File: rtl/acc_drain.sv
// acc_drain
// ---------
// Read-side controller for the accumulator buffer. A start command walks a
// range of accumulator rows through the buffer's synchronous read port. Each
// 16-lane row of signed partial sums is post-processed:
//   arithmetic right shift -> optional ReLU -> saturation to signed OUT_SIZE.
// Results are queued in a small FIFO and streamed out on a valid/ready port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command strobe (sampled only in IDLE)
//   base_addr, row_cnt  first row and number of rows (0..2^ADDR_WIDTH)
//   shift, relu_en      post-processing controls, latched on start
//   busy, done          RUN indicator, one-cycle completion pulse
//   acc_enb, acc_addrb  accumulator read request (data returns next cycle)
//   acc_doutb           accumulator read data
//   m_valid, m_ready,
//   m_data, m_last      output row stream; m_last marks the command's final row
//
// Handshake: a row transfers in any cycle where m_valid and m_ready are both
// high. Once m_valid is high, m_data and m_last hold until that transfer, and
// m_valid never drops without a transfer. m_ready may toggle freely.
//
// The FSM state is held in r_state for observation by checkers.

module acc_drain #(
  parameter int DATA_SIZE  = 20,
  parameter int DATA_NUM   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int OUT_SIZE   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH:0]           row_cnt,
  input  logic [4:0]                    shift,
  input  logic                          relu_en,
  output logic                          busy,
  output logic                          done,
  output logic                          acc_enb,
  output logic [ADDR_WIDTH-1:0]         acc_addrb,
  input  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_NUM*OUT_SIZE-1:0]  m_data,
  output logic                          m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = DATA_SIZE'((1 <<< (OUT_SIZE - 1)) - 1);
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = DATA_SIZE'(-(1 <<< (OUT_SIZE - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  logic                          r_enb;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic [ADDR_WIDTH:0]           r_issue_left;
  logic [ADDR_WIDTH:0]           r_push_left;
  logic [4:0]                    r_shift;
  logic                          r_relu;
  logic                          r_cap_vld;

  logic [DATA_NUM*OUT_SIZE-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]         r_fifo_last;
  logic [PW-1:0]                 r_wr_ptr;
  logic [PW-1:0]                 r_rd_ptr;
  logic [CW-1:0]                 r_count;

  logic                          w_push;
  logic                          w_pop;
  logic                          w_push_last;
  logic                          w_start_run;
  logic                          w_issue_ok;
  logic [CW-1:0]                 w_occ_next;
  logic [CW:0]                   w_inflight;
  logic [DATA_NUM*OUT_SIZE-1:0]  w_row;

  // ---------------------------------------------------------------------------
  // Lane post-processing
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_SIZE-1:0] proc_lane(
    input logic [DATA_SIZE-1:0] x,
    input logic [4:0]           sh,
    input logic                 relu
  );
    logic signed [DATA_SIZE-1:0] y;
    y = $signed(x) >>> sh;
    if (relu && y[DATA_SIZE-1]) begin
      y = '0;
    end
    if (y > SAT_MAX) begin
      y = SAT_MAX;
    end else if (y < SAT_MIN) begin
      y = SAT_MIN;
    end
    return y[OUT_SIZE-1:0];
  endfunction

  always_comb begin
    w_row = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      w_row[i*OUT_SIZE +: OUT_SIZE] = proc_lane(acc_doutb[i*DATA_SIZE +: DATA_SIZE], r_shift, r_relu);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (row_cnt != '0) ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_pop && m_last) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  assign w_push      = r_cap_vld;
  assign w_pop       = m_valid & m_ready;
  assign w_push_last = (r_push_left == (ADDR_WIDTH + 1)'(1));
  assign w_start_run = (r_state == S_IDLE) && start && (row_cnt != '0);
  assign w_occ_next  = r_count + CW'(w_push) - CW'(w_pop);

  // The read being issued this cycle (r_enb) lands in the FIFO at the end of
  // the next cycle, so it still counts as in flight when deciding whether the
  // next registered read can be granted. Every granted read is then
  // guaranteed a free FIFO slot even if the sink never pops.
  assign w_inflight  = {1'b0, w_occ_next} + (CW + 1)'(r_enb);
  assign w_issue_ok  = (r_issue_left != '0) && (w_inflight < (CW + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enb        <= 1'b0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_push_left  <= '0;
      r_shift      <= '0;
      r_relu       <= 1'b0;
      r_cap_vld    <= 1'b0;
    end else begin
      // Buffer data is valid exactly one cycle after an enable.
      r_cap_vld <= r_enb;

      if (w_start_run) begin
        r_enb        <= 1'b1;
        r_addr       <= base_addr;
        r_issue_left <= row_cnt - (ADDR_WIDTH + 1)'(1);
        r_shift      <= shift;
        r_relu       <= relu_en;
      end else if ((r_state == S_RUN) && w_issue_ok) begin
        // Address wraps naturally modulo 2^ADDR_WIDTH.
        r_enb        <= 1'b1;
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_issue_left <= r_issue_left - (ADDR_WIDTH + 1)'(1);
      end else begin
        r_enb        <= 1'b0;
      end

      if (w_start_run) begin
        r_push_left <= row_cnt;
      end else if (w_push) begin
        r_push_left <= r_push_left - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  assign acc_enb   = r_enb;
  assign acc_addrb = r_addr;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_row;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_occ_next;
    end
  end

  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign m_last  = m_valid & r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain
// ------------
// Directed bench for acc_drain. Holds a behavioural accumulator buffer
// (synchronous read, data held while enb=0), a scoreboard queue of expected
// output rows built from a lane model, and a monitor that checks every
// output handshake and stall stability. Inputs change 1 time unit after the
// rising edge; directed checks are made there, monitor checks on the
// falling edge.

module tb_acc_drain;

  localparam int DS = 20;
  localparam int DN = 16;
  localparam int AW = 4;
  localparam int OS = 8;
  localparam int FD = 4;
  localparam int RW = DN * DS;
  localparam int OW = DN * OS;
  localparam int EW = OW + 1;
  localparam int CKW = 160;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_cnt;
  logic [4:0]    shift;
  logic          relu_en;
  logic          busy;
  logic          done;
  logic          acc_enb;
  logic [AW-1:0] acc_addrb;
  logic [RW-1:0] acc_doutb;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  acc_drain #(
    .DATA_SIZE (DS),
    .DATA_NUM  (DN),
    .ADDR_WIDTH(AW),
    .OUT_SIZE  (OS),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .row_cnt  (row_cnt),
    .shift    (shift),
    .relu_en  (relu_en),
    .busy     (busy),
    .done     (done),
    .acc_enb  (acc_enb),
    .acc_addrb(acc_addrb),
    .acc_doutb(acc_doutb),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  // Accumulator buffer model
  logic [RW-1:0] mem [16];

  always @(posedge clk) begin
    if (acc_enb) begin
      acc_doutb <= mem[acc_addrb];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            addr_log[$];
  int            n_err = 0;
  int            n_chk = 0;
  int            enb_cnt = 0;
  int            done_cnt = 0;
  int            hs_cnt = 0;
  bit            stall_prev = 1'b0;
  logic [EW-1:0] prev_head;

  task automatic chk(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] exp_row(input logic [RW-1:0] r, input int sh, input bit relu);
    logic [OW-1:0]         o;
    logic signed [DS-1:0]  xs;
    int                    v;
    o = '0;
    for (int i = 0; i < DN; i++) begin
      xs = r[i*DS +: DS];
      v  = int'(xs);
      v  = v >>> sh;
      if (relu && v < 0) v = 0;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      o[i*OS +: OS] = OS'(v);
    end
    return o;
  endfunction

  // Monitor: read-request log, done pulses, output rows, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_enb) begin
        enb_cnt++;
        addr_log.push_back(int'(acc_addrb));
      end
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_head});
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL extra_row: observed=%0h expected=none", {m_last, m_data});
        end
        if (exp_q.size() != 0) begin
          chk("row", {m_last, m_data}, exp_q.pop_front());
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_head  = {m_last, m_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int row, input int lane, input int val);
    mem[row][lane*DS +: DS] = DS'(val);
  endtask

  // Queues the expected rows and pulses start for one cycle (cycle 0).
  // Returns 1 time unit into cycle 1.
  task automatic issue(input int b, input int c, input int sh, input bit relu);
    for (int r = 0; r < c; r++) begin
      exp_q.push_back({(r == c - 1), exp_row(mem[(b + r) % 16], sh, relu)});
    end
    base_addr = AW'(b);
    row_cnt   = (AW + 1)'(c);
    shift     = 5'(sh);
    relu_en   = relu;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      if (done) seen = 1'b1;
      else step();
    end
    n_chk++;
    assert (seen) else begin
      n_err++;
      $error("FAIL %s: observed=no_done expected=done within %0d cycles", tag, bound);
    end
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    int h0;
    int d0;
    int exp_a[4];

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    row_cnt   = '0;
    shift     = '0;
    relu_en   = 1'b0;
    m_ready   = 1'b0;
    for (int r = 0; r < 16; r++) mem[r] = '0;

    step();
    step();
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    chk("rst_enb",   acc_enb,   0);
    chk("rst_addr",  acc_addrb, 0);
    chk("rst_valid", m_valid,   0);
    chk("rst_last",  m_last,    0);
    chk("rst_data",  m_data,    0);
    rst_n = 1'b1;
    step();

    // --- 1: four rows, pass-through values, exact timing -----------------
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < DN; l++) set_lane(r, l, r * 10 + l);
    m_ready = 1'b1;
    e0 = enb_cnt;
    issue(0, 4, 0, 0);                          // now cycle 1
    chk("t1_c1_enb",  acc_enb,   1);
    chk("t1_c1_busy", busy,      1);
    chk("t1_c1_addr", acc_addrb, 0);
    step(); step();                             // cycle 3
    chk("t1_c3_valid", m_valid, 1);
    chk("t1_c3_lane5", m_data[5*OS +: OS], 8'd5);
    chk("t1_c3_last",  m_last, 0);
    step(); step(); step();                     // cycle 6
    chk("t1_c6_lane15", m_data[15*OS +: OS], 8'd45);
    chk("t1_c6_last",   m_last, 1);
    step();                                     // cycle 7
    chk("t1_c7_done",  done,    1);
    chk("t1_c7_busy",  busy,    0);
    chk("t1_c7_valid", m_valid, 0);
    step();                                     // cycle 8
    chk("t1_c8_done", done, 0);
    chk("t1_enb_cnt", enb_cnt - e0, 4);

    // --- 2: lane arithmetic ----------------------------------------------
    set_lane(5, 0, -300);
    set_lane(5, 1, 32'h7FFFF);
    set_lane(5, 2, 40);
    set_lane(5, 3, -1);
    issue(5, 1, 1, 0);
    step(); step();
    chk("sat_neg",    m_data[0*OS +: OS], 8'h80);
    chk("shift_neg1", m_data[3*OS +: OS], 8'hFF);
    chk("single_last", m_last, 1);
    wait_done("t2a_done", 10);
    issue(5, 1, 1, 1);
    step(); step();
    chk("relu_lane0", m_data[0*OS +: OS], 8'h00);
    chk("relu_lane3", m_data[3*OS +: OS], 8'h00);
    wait_done("t2b_done", 10);
    issue(5, 1, 4, 0);
    step(); step();
    chk("sat_pos", m_data[1*OS +: OS], 8'h7F);
    wait_done("t2c_done", 10);
    issue(5, 1, 2, 0);
    step(); step();
    chk("shift2_40",   m_data[2*OS +: OS], 8'h0A);
    chk("shift2_m300", m_data[0*OS +: OS], 8'hB5);
    wait_done("t2d_done", 10);

    // --- 3: address wrap ---------------------------------------------------
    for (int r = 14; r < 16; r++)
      for (int l = 0; l < DN; l++) set_lane(r, l, r + l);
    addr_log.delete();
    issue(14, 4, 0, 0);
    wait_done("t3_done", 20);
    exp_a = '{14, 15, 0, 1};
    chk("wrap_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", addr_log[i], exp_a[i]);

    // --- 4: full buffer under backpressure --------------------------------
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < DN; l++) set_lane(r, l, r * 8 + l - 60);
    m_ready = 1'b0;
    e0 = enb_cnt;
    issue(0, 16, 0, 0);                         // cycle 1
    for (int k = 0; k < 9; k++) step();         // cycle 10
    chk("bp_enb_cnt", enb_cnt - e0, 4);
    chk("bp_enb_off", acc_enb, 0);
    chk("bp_valid",   m_valid, 1);
    chk("bp_head",    m_data[0*OS +: OS], 8'hC4);
    m_ready = 1'b1;
    wait_done("t4_done", 40);
    chk("bp_enb_total", enb_cnt - e0, 16);
    chk("bp_q_empty",   exp_q.size(), 0);

    // --- 5: zero-row command ---------------------------------------------
    e0 = enb_cnt;
    issue(3, 0, 0, 0);                          // cycle 1
    chk("z_done",  done,    1);
    chk("z_busy",  busy,    0);
    chk("z_enb",   acc_enb, 0);
    step();
    chk("z_done_off", done, 0);
    chk("z_valid",    m_valid, 0);
    chk("z_reads",    enb_cnt - e0, 0);

    // --- 6: start during RUN is ignored -----------------------------------
    h0 = hs_cnt;
    issue(0, 4, 0, 0);                          // cycle 1
    step();                                     // cycle 2
    base_addr = 4'd8;
    row_cnt   = 5'd2;
    start     = 1'b1;
    step(); step();                             // cycle 4
    start = 1'b0;
    wait_done("t6_done", 20);
    step(); step(); step();
    chk("ign_idle", {busy, m_valid, acc_enb}, 0);
    chk("ign_rows", hs_cnt - h0, 4);
    chk("ign_q",    exp_q.size(), 0);

    // --- 7: reset mid-command, then recovery ------------------------------
    h0 = hs_cnt;
    issue(0, 8, 0, 0);                          // cycle 1
    step(); step(); step(); step();             // cycle 5
    chk("ra_rows", hs_cnt - h0, 2);
    rst_n = 1'b0;
    #1;
    chk("ra_outs", {busy, done, acc_enb, acc_addrb, m_valid, m_last, m_data}, 0);
    exp_q.delete();
    d0 = done_cnt;
    step(); step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("ra_no_done", done_cnt - d0, 0);
    chk("ra_idle",    {busy, m_valid, acc_enb}, 0);
    h0 = hs_cnt;
    issue(2, 3, 0, 0);
    wait_done("t7_done", 20);
    chk("ra_new_rows", hs_cnt - h0, 3);
    chk("ra_new_q",    exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
# acc_drain

Read-side controller for the systolic array's accumulator buffer. On a start command it walks a range of accumulator rows through the buffer's read port and post-processes each 16-lane row of 20-bit partial sums. Processing is arithmetic right shift, optional ReLU, and saturation to signed 8-bit. Result rows are streamed out on a valid/ready interface toward the unified buffer. It is the consumer at the far end of the accumulator's read port.

## Interface

Parameters:
- DATA_SIZE, 20, accumulator lane width (signed)
- DATA_NUM, 16, lanes per row
- ADDR_WIDTH, 4, accumulator address width (16 rows)
- OUT_SIZE, 8, output lane width (signed)
- FIFO_DEPTH, 4, output FIFO entries

Ports (clock and reset are already decided):
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only while busy=0
- base_addr  in  ADDR_WIDTH  first row address, captured on start
- row_cnt  in  ADDR_WIDTH+1  rows to drain (0..16), captured on start
- shift  in  5  right-shift amount (0..19), captured on start
- relu_en  in  1  clamp negatives to 0, captured on start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- acc_enb  out  1  accumulator read enable
- acc_addrb  out  ADDR_WIDTH  accumulator read address
- acc_doutb  in  DATA_NUM*DATA_SIZE  accumulator read data; valid the cycle after acc_enb
- m_valid  out  1  output row valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_NUM*OUT_SIZE  output row; lane i at bits [i*OUT_SIZE +: OUT_SIZE]
- m_last  out  1  marks the final row of a command

## Operation

- The FSM has three states: IDLE, RUN and FIN.
- IDLE -> RUN occurs on start with row_cnt≠0.
  - base_addr, row_cnt, shift and relu_en are latched.
- IDLE -> FIN occurs on start with row_cnt=0. No reads are issued.
- RUN -> FIN occurs on the m_valid & m_ready & m_last handshake.
- FIN -> IDLE occurs unconditionally. done=1 while in FIN.
- busy=1 in RUN, 0 in IDLE and FIN. A start in FIN is ignored; a start during RUN is ignored.
- Read issue rules in RUN:
  - acc_enb is asserted when rows remain to issue and (FIFO occupancy + outstanding reads) < FIFO_DEPTH.
  - Outstanding reads are those issued but not yet written into the FIFO.
  - acc_addrb starts at base_addr and increments by 1 per issue, wrapping modulo 2^ADDR_WIDTH (e.g. base 14, count 4 reads 14, 15, 0, 1).
- Capture rule: acc_doutb is captured only in the cycle following an acc_enb. The buffer holds its data while enb=0, so no other cycle is captured.
- Lane processing, per 20-bit signed lane x, in this order:
  - y = x >>> shift (arithmetic shift).
  - If relu_en and y<0, then y=0.
  - Saturate y to [-128, 127].
- Processed rows enter a FIFO_DEPTH-entry FIFO. m_data, m_valid and m_last are the FIFO head.
- m_last is set on the entry carrying the row_cnt-th row.
- Valid/ready handshake:
  - Once m_valid=1, m_data and m_last hold stable until m_ready=1.
  - A FIFO push and pop in the same cycle are both allowed.
- The block does not check for write/read hazards against the accumulator's write port. The sequencer must not write rows being drained.

## Timing

- Reset values: FSM=IDLE, busy=0, done=0, acc_enb=0, acc_addrb=0, m_valid=0, m_last=0, m_data=0. The FIFO and counters are cleared.
- Reset mid-command aborts immediately. No further acc_enb is issued, the FIFO is discarded and no done pulse is produced.
- Start latency:
  - start is sampled at cycle 0.
  - acc_enb is asserted at cycle 1 (registered).
  - acc_doutb is valid at cycle 2 and the row is pushed at the end of cycle 2.
  - m_valid rises at cycle 3.
- With m_ready held at 1, throughput is one row per cycle. Draining N rows takes handshakes in cycles 3..N+2, done at cycle N+3, and busy=0 from cycle N+3.
- Backpressure:
  - With m_ready=0 the FIFO fills to FIFO_DEPTH and acc_enb stops.
  - No read is ever issued whose data could not be pushed.
- row_cnt=0: done at cycle 1, no acc_enb, no m_valid.
- row_cnt=16 covers the full buffer and returns to base_addr without re-reading any row.

## Test plan

- Preload rows 0..3 with lanes = row*10+lane; start base 0, count 4, shift 0, relu off, m_ready=1 -> 4 rows out at cycles 3..6, values unchanged, m_last on row 3 only, done at cycle 7.
- Lane value -300 with shift 1: relu off -> -128 (saturated); relu on -> 0. Lane 0x7FFFF with shift 4 -> 127. Lane 40 with shift 2 -> 10.
- base 14, count 4 -> acc_addrb sequence 14, 15, 0, 1; output order matches.
- Count 16 with m_ready=0 for 10 cycles -> exactly 4 acc_enb pulses then a stall, m_data stable. Then m_ready=1 -> all 16 rows in order with no duplicates and no drops.
- count 0 -> done pulse at cycle 1, zero reads. start asserted during RUN -> ignored, and the current command completes unchanged.
- rst_n asserted after 2 of 8 rows -> all outputs at reset values immediately, no done. A new command afterward runs correctly.
